// File: rtl/id_operand_stage.sv
// Decode/operand-fetch stage after the register file; 1-cycle accept-to-output latency, one bubble on load-use.
// Optional same-cycle write-back bypass selected by ID_WB_BYPASS_EN; upstream stalls via InReady when EX backpressures, a hazard is pending or Flush is high.
module id_operand_stage #(
    parameter int          DATA_W  = 32,
    parameter int          ADDR_W  = 5,
    parameter logic [5:0]  LOAD_OP = 6'b100011
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              InValid,
    output logic              InReady,
    input  logic [31:0]       Instr,
    output logic [ADDR_W-1:0] Ard1,
    output logic [ADDR_W-1:0] Ard2,
    input  logic [DATA_W-1:0] RfD1,
    input  logic [DATA_W-1:0] RfD2,
    input  logic [DATA_W-1:0] WbDin,
    input  logic [ADDR_W-1:0] WbAwr,
    input  logic              WbWrEn,
    input  logic              Flush,
    output logic              OutValid,
    input  logic              OutReady,
    output logic [DATA_W-1:0] OpA,
    output logic [DATA_W-1:0] OpB,
    output logic [DATA_W-1:0] Imm,
    output logic [5:0]        Opcode,
    output logic [ADDR_W-1:0] Rs,
    output logic [ADDR_W-1:0] Rt,
    output logic [ADDR_W-1:0] Rd
);

    logic [5:0]        in_op;
    logic [ADDR_W-1:0] in_rs, in_rt, in_rd;
    logic [DATA_W-1:0] in_imm;
    logic              adv, haz, accept;
    logic              byp_a, byp_b;
    logic [DATA_W-1:0] op_a_sel, op_b_sel;

    logic              out_vld_q, out_vld_d;
    logic [DATA_W-1:0] op_a_q, op_a_d, op_b_q, op_b_d, imm_q, imm_d;
    logic [5:0]        opcode_q, opcode_d;
    logic [ADDR_W-1:0] rs_q, rs_d, rt_q, rt_d, rd_q, rd_d;
    logic              load_pending_q, load_pending_d;
    logic [ADDR_W-1:0] load_dst_q, load_dst_d;

    assign in_op  = Instr[31:26];
    assign in_rs  = Instr[21 +: ADDR_W];
    assign in_rt  = Instr[16 +: ADDR_W];
    assign in_rd  = Instr[11 +: ADDR_W];
    assign in_imm = {{(DATA_W-16){Instr[15]}}, Instr[15:0]};

    assign Ard1 = in_rs;
    assign Ard2 = in_rt;

`ifdef ID_WB_BYPASS_EN
    assign byp_a = WbWrEn && (WbAwr != '0) && (WbAwr == in_rs);
    assign byp_b = WbWrEn && (WbAwr != '0) && (WbAwr == in_rt);
`else
    // Without the bypass the write-back port is observed only by the RF itself.
    logic wb_unused;
    assign wb_unused = ^{WbDin, WbAwr, WbWrEn};
    assign byp_a = 1'b0;
    assign byp_b = 1'b0;
`endif

    assign op_a_sel = (in_rs == '0) ? '0 : (byp_a ? WbDin : RfD1);
    assign op_b_sel = (in_rt == '0) ? '0 : (byp_b ? WbDin : RfD2);

    // A load still in ID/EX cannot forward its data yet, so a dependent read must wait one cycle.
    assign adv     = !out_vld_q || OutReady;
    assign haz     = load_pending_q && (load_dst_q != '0) &&
                     ((in_rs == load_dst_q) || (in_rt == load_dst_q));
    assign InReady = adv && !haz && !Flush;
    assign accept  = InValid && InReady;

    always_comb begin
        out_vld_d      = out_vld_q;
        op_a_d         = op_a_q;
        op_b_d         = op_b_q;
        imm_d          = imm_q;
        opcode_d       = opcode_q;
        rs_d           = rs_q;
        rt_d           = rt_q;
        rd_d           = rd_q;
        load_pending_d = load_pending_q;
        load_dst_d     = load_dst_q;
        if (accept) begin
            out_vld_d      = 1'b1;
            op_a_d         = op_a_sel;
            op_b_d         = op_b_sel;
            imm_d          = in_imm;
            opcode_d       = in_op;
            rs_d           = in_rs;
            rt_d           = in_rt;
            rd_d           = in_rd;
            load_pending_d = (in_op == LOAD_OP);
            load_dst_d     = in_rt;
        end else if (adv || Flush) begin
            // Bubble or kill: payload fields keep stale values, only validity drops.
            out_vld_d      = 1'b0;
            load_pending_d = 1'b0;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            out_vld_q      <= 1'b0;
            op_a_q         <= '0;
            op_b_q         <= '0;
            imm_q          <= '0;
            opcode_q       <= '0;
            rs_q           <= '0;
            rt_q           <= '0;
            rd_q           <= '0;
            load_pending_q <= 1'b0;
            load_dst_q     <= '0;
        end else begin
            out_vld_q      <= out_vld_d;
            op_a_q         <= op_a_d;
            op_b_q         <= op_b_d;
            imm_q          <= imm_d;
            opcode_q       <= opcode_d;
            rs_q           <= rs_d;
            rt_q           <= rt_d;
            rd_q           <= rd_d;
            load_pending_q <= load_pending_d;
            load_dst_q     <= load_dst_d;
        end
    end

    assign OutValid = out_vld_q;
    assign OpA      = op_a_q;
    assign OpB      = op_b_q;
    assign Imm      = imm_q;
    assign Opcode   = opcode_q;
    assign Rs       = rs_q;
    assign Rt       = rt_q;
    assign Rd       = rd_q;

endmodule

// File: tb/tb_id_operand_stage.sv
// Directed bench for id_operand_stage: vector table plus reset, load-use, backpressure and flush sequences.
module tb_id_operand_stage;

`ifdef ID_WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif
    localparam logic [5:0] LD = 6'b100011;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        InValid = 1'b0, InReady;
    logic [31:0] Instr = '0;
    logic [4:0]  Ard1, Ard2;
    logic [31:0] RfD1 = '0, RfD2 = '0, WbDin = '0;
    logic [4:0]  WbAwr = '0;
    logic        WbWrEn = 1'b0, Flush = 1'b0, OutValid, OutReady = 1'b1;
    logic [31:0] OpA, OpB, Imm;
    logic [5:0]  Opcode;
    logic [4:0]  Rs, Rt, Rd;

    int checks = 0;
    int errors = 0;

    id_operand_stage dut (
        .CLK(CLK), .RST(RST), .InValid(InValid), .InReady(InReady), .Instr(Instr),
        .Ard1(Ard1), .Ard2(Ard2), .RfD1(RfD1), .RfD2(RfD2), .WbDin(WbDin),
        .WbAwr(WbAwr), .WbWrEn(WbWrEn), .Flush(Flush), .OutValid(OutValid),
        .OutReady(OutReady), .OpA(OpA), .OpB(OpB), .Imm(Imm), .Opcode(Opcode),
        .Rs(Rs), .Rt(Rt), .Rd(Rd)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [5:0]  op;
        logic [4:0]  rs, rt;
        logic [15:0] imm;
        logic [31:0] rfd1, rfd2;
        logic        wben;
        logic [4:0]  wbawr;
        logic [31:0] wbdin;
        logic [31:0] e_opa, e_opb, e_imm;
        logic [4:0]  e_rd;
    } vec_t;

    vec_t vecs[10];

    function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] rs,
                                       input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        // op rs rt imm rfd1 rfd2 wben wbawr wbdin | opa opb imm rd
        vecs[0] = '{6'h00, 5'd3,  5'd4,  16'hFFF0, 32'd5,    32'd7,     1'b0, 5'd0, 32'h0,
                    32'd5, 32'd7, 32'hFFFFFFF0, 5'd31};
        vecs[1] = '{6'h0D, 5'd0,  5'd2,  16'h0010, 32'hDEAD, 32'hAA,    1'b0, 5'd0, 32'h0,
                    32'h0, 32'hAA, 32'h10, 5'd0};
        vecs[2] = '{6'h04, 5'd1,  5'd0,  16'h8000, 32'h11,   32'hBEEF,  1'b0, 5'd0, 32'h0,
                    32'h11, 32'h0, 32'hFFFF8000, 5'd16};
        vecs[3] = '{6'h08, 5'd8,  5'd9,  16'h7FFF, 32'h0,    32'h22,    1'b1, 5'd8, 32'h1234,
                    (BYP ? 32'h1234 : 32'h0), 32'h22, 32'h7FFF, 5'd15};
        vecs[4] = '{6'h08, 5'd8,  5'd9,  16'h7FFF, 32'h55,   32'h22,    1'b1, 5'd0, 32'h1234,
                    32'h55, 32'h22, 32'h7FFF, 5'd15};
        vecs[5] = '{6'h2B, 5'd5,  5'd6,  16'h1234, 32'h1,    32'h2,     1'b1, 5'd6, 32'hABCD,
                    32'h1, (BYP ? 32'hABCD : 32'h2), 32'h1234, 5'd2};
        vecs[6] = '{6'h00, 5'd6,  5'd6,  16'h0800, 32'h3,    32'h4,     1'b0, 5'd6, 32'hABCD,
                    32'h3, 32'h4, 32'h800, 5'd1};
        vecs[7] = '{LD,    5'd2,  5'd10, 16'hFFFF, 32'h40,   32'h41,    1'b0, 5'd0, 32'h0,
                    32'h40, 32'h41, 32'hFFFFFFFF, 5'd31};
        vecs[8] = '{6'h00, 5'd11, 5'd12, 16'h0004, 32'h60,   32'h61,    1'b0, 5'd0, 32'h0,
                    32'h60, 32'h61, 32'h4, 5'd0};
        vecs[9] = '{6'h08, 5'd0,  5'd0,  16'h0000, 32'h77,   32'h88,    1'b1, 5'd0, 32'h99,
                    32'h0, 32'h0, 32'h0, 5'd0};

        // Reset state
        #1;
        chk("rst_outvalid", {31'b0, OutValid}, 32'd0);
        chk("rst_opa", OpA, 32'd0);
        chk("rst_imm", Imm, 32'd0);
        tick();
        RST = 1'b0;
        #1;
        chk("rst_inready", {31'b0, InReady}, 32'd1);

        // Streaming table, one instruction per cycle
        for (int i = 0; i < 10; i++) begin
            InValid = 1'b1;
            Instr   = mk(vecs[i].op, vecs[i].rs, vecs[i].rt, vecs[i].imm);
            RfD1 = vecs[i].rfd1;  RfD2 = vecs[i].rfd2;
            WbWrEn = vecs[i].wben; WbAwr = vecs[i].wbawr; WbDin = vecs[i].wbdin;
            #1;
            chk($sformatf("v%0d_inready", i), {31'b0, InReady}, 32'd1);
            chk($sformatf("v%0d_ard1", i), {27'b0, Ard1}, {27'b0, vecs[i].rs});
            tick();
            chk($sformatf("v%0d_outvalid", i), {31'b0, OutValid}, 32'd1);
            chk($sformatf("v%0d_opa", i), OpA, vecs[i].e_opa);
            chk($sformatf("v%0d_opb", i), OpB, vecs[i].e_opb);
            chk($sformatf("v%0d_imm", i), Imm, vecs[i].e_imm);
            chk($sformatf("v%0d_opcode", i), {26'b0, Opcode}, {26'b0, vecs[i].op});
            chk($sformatf("v%0d_rs", i), {27'b0, Rs}, {27'b0, vecs[i].rs});
            chk($sformatf("v%0d_rt", i), {27'b0, Rt}, {27'b0, vecs[i].rt});
            chk($sformatf("v%0d_rd", i), {27'b0, Rd}, {27'b0, vecs[i].e_rd});
        end
        WbWrEn = 1'b0; WbAwr = '0; WbDin = '0;

        // Mid-stream reset, first accept right after release
        Instr = mk(6'h00, 5'd3, 5'd4, 16'h0001); RfD1 = 32'hA1; RfD2 = 32'hB2;
        #2 RST = 1'b1;
        #1;
        chk("mrst_outvalid", {31'b0, OutValid}, 32'd0);
        chk("mrst_opa", OpA, 32'd0);
        chk("mrst_opb", OpB, 32'd0);
        chk("mrst_imm", Imm, 32'd0);
        tick();
        RST = 1'b0;
        #1;
        chk("mrst_inready", {31'b0, InReady}, 32'd1);
        tick();
        chk("mrst_accept_vld", {31'b0, OutValid}, 32'd1);
        chk("mrst_accept_opa", OpA, 32'hA1);

        // Load-use: lw r9, then a reader of r9
        Instr = mk(LD, 5'd1, 5'd9, 16'h0000); RfD1 = 32'h5; RfD2 = 32'h6;
        tick();
        chk("lu_lw_vld", {31'b0, OutValid}, 32'd1);
        chk("lu_lw_op", {26'b0, Opcode}, {26'b0, LD});
        Instr = mk(6'h00, 5'd9, 5'd2, 16'h0000); RfD1 = 32'h99; RfD2 = 32'h22;
        #1;
        chk("lu_hold_inready", {31'b0, InReady}, 32'd0);
        tick();
        chk("lu_bubble_vld", {31'b0, OutValid}, 32'd0);
        chk("lu_bubble_inready", {31'b0, InReady}, 32'd1);
        tick();
        chk("lu_dep_vld", {31'b0, OutValid}, 32'd1);
        chk("lu_dep_rs", {27'b0, Rs}, 32'd9);
        chk("lu_dep_opa", OpA, 32'h99);

        // Load to r0 never stalls a reader of r0
        Instr = mk(LD, 5'd1, 5'd0, 16'h0000);
        tick();
        Instr = mk(6'h00, 5'd0, 5'd0, 16'h0000);
        #1;
        chk("lu_r0_inready", {31'b0, InReady}, 32'd1);
        tick();

        // Backpressure: three stalled cycles, then flush while stalled
        Instr = mk(6'h01, 5'd3, 5'd4, 16'h00AA); RfD1 = 32'hC0; RfD2 = 32'hC1;
        tick();
        OutReady = 1'b0;
        Instr = mk(6'h02, 5'd5, 5'd6, 16'h00BB); RfD1 = 32'hD0; RfD2 = 32'hD1;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk($sformatf("bp%0d_inready", c), {31'b0, InReady}, 32'd0);
            tick();
            chk($sformatf("bp%0d_vld", c), {31'b0, OutValid}, 32'd1);
            chk($sformatf("bp%0d_opa", c), OpA, 32'hC0);
            chk($sformatf("bp%0d_imm", c), Imm, 32'hAA);
        end
        Flush = 1'b1;
        #1;
        chk("fl_inready", {31'b0, InReady}, 32'd0);
        tick();
        chk("fl_vld", {31'b0, OutValid}, 32'd0);
        OutReady = 1'b1;
        #1;
        chk("fl_inready2", {31'b0, InReady}, 32'd0);
        tick();
        chk("fl_noaccept", {31'b0, OutValid}, 32'd0);
        Flush = 1'b0;
        #1;
        chk("fl_release_inready", {31'b0, InReady}, 32'd1);
        tick();
        chk("fl_after_vld", {31'b0, OutValid}, 32'd1);
        chk("fl_after_opa", OpA, 32'hD0);

        // Flush clears a pending load so the dependent read is not stalled
        Instr = mk(LD, 5'd1, 5'd9, 16'h0000);
        tick();
        InValid = 1'b0; Flush = 1'b1;
        tick();
        Flush = 1'b0; InValid = 1'b1;
        Instr = mk(6'h00, 5'd9, 5'd9, 16'h0000);
        #1;
        chk("fl_load_inready", {31'b0, InReady}, 32'd1);
        tick();
        InValid = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
